hd_vector_gen: RTL
==================

# hd_vector_gen

Sequential stimulus generator for the Hamming-distance miter flow. It enumerates every error mask of one programmed weight over a WIDTH-bit word. For each mask it emits the pair (a = captured base, b = base ^ mask) through a valid/ready stream. Output pairs drive the mhd miter inputs and approximate-circuit checks, so each pair's Hamming distance is known by construction.

## Interface
- WIDTH, 18, word width of base, out_a, out_b
- MAX_HD, 4, largest legal requested distance
- CNT_W, 16, width of the emitted-vector counter; must hold C(WIDTH, MAX_HD)
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- base  in  WIDTH  reference word; captured on accepted start
- weight  in  3  requested Hamming distance; captured on accepted start
- abort  in  1  synchronous cancel; returns to IDLE, no done
- out_valid  out  1  out_a/out_b/out_hd valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_a  out  WIDTH  captured base
- out_b  out  WIDTH  base ^ current mask
- out_hd  out  3  captured weight; popcount(out_a ^ out_b) always equals it
- busy  out  1  high in GEN and DONE
- done  out  1  one-cycle pulse after the last pair is accepted
- err  out  1  one-cycle pulse when start carries an illegal weight
- count  out  CNT_W  pairs accepted in the current or last run

## Operation
- FSM states: IDLE, GEN, DONE.
- IDLE, start=1, 1 ≤ weight ≤ MAX_HD and weight ≤ WIDTH:
  - capture base and weight
  - mask = (1<<weight)-1, count = 0
  - go to GEN
- IDLE, start=1, illegal weight (0 or > MAX_HD): pulse err next cycle, stay IDLE, count unchanged.
- GEN: out_valid=1. On handshake, count += 1.
  - If mask == ((1<<weight)-1) << (WIDTH-weight), go to DONE.
  - Otherwise mask = next larger integer with the same popcount (Gosper successor). Implementation choice is free if the order matches.
- Masks are emitted in strictly increasing numeric order, exactly C(WIDTH, weight) of them, no repeats.
- DONE: done=1 for exactly one cycle, then IDLE. busy is still high in DONE.
- abort = 1 in GEN or DONE → IDLE next cycle.
  - out_valid drops; done is not pulsed.
  - count keeps the number already accepted.
  - abort has priority over a simultaneous handshake; that pair is not counted.
- start is ignored while busy.
- abort in IDLE has no effect.
- out_a, out_b, out_hd hold their values while out_valid & !out_ready. They change only after a handshake.
- Outputs outside GEN: last values retained; don't-care to consumers.

## Timing
- Reset values:
  - state IDLE
  - out_valid 0, busy 0, done 0, err 0, count 0
  - out_a 0, out_b 0, out_hd 0
- Reset is asynchronous and may be asserted at any time, including mid-run. Outputs reach reset values immediately. After release, the block waits in IDLE for a new start.
- start accepted at edge n → out_valid=1 and first pair on outputs from cycle n+1.
- Throughput: one pair per cycle while out_ready=1. No bubbles between masks.
- Last handshake at edge m → done=1 during cycle m+1; busy=0 and IDLE from m+2. A start at edge m+2 is accepted.
- Illegal start at edge n → err=1 during cycle n+1 only.
- out_valid never depends combinationally on out_ready.

## Test plan
- weight=1, base=0, out_ready=1:
  - 18 pairs, out_b = 0x00001, 0x00002 … 0x20000 on consecutive cycles
  - done one cycle after the last pair; count=18
- weight=4, base=0x2AAAA, out_ready=1:
  - 3060 pairs; first out_b = 0x2AAAA^0x0000F, last out_b = 0x2AAAA^0x3C000
  - scoreboard: popcount(out_a^out_b)=4 and strictly increasing mask on every pair; count=3060
- weight=2 with out_ready pseudo-random 50%:
  - 153 pairs; outputs stable across all stalled cycles; masks identical to the out_ready=1 run
- weight=0, then weight=5:
  - err pulse one cycle each; out_valid and busy stay 0; count unchanged
- start during GEN is ignored.
- abort after 10 handshakes: IDLE next cycle, no done, count=10.
- rst asserted mid-run: all outputs at reset values immediately. New start after release begins again at mask 0x00001 for weight 1.

Source files
------------

// File: rtl/hd_vector_gen.sv
// hd_vector_gen: stimulus generator for the Hamming-distance miter flow.
// Enumerates every WIDTH-bit error mask of a programmed weight in increasing
// numeric order and emits (a = base, b = base ^ mask) on a valid/ready stream.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, base, weight run request (sampled in IDLE), reference word, distance
//   abort               synchronous cancel of a run
//   out_valid/out_ready stream handshake
//   out_a, out_b, out_hd pair payload and its Hamming distance
//   busy, done, err     run active, end-of-run pulse, illegal-weight pulse
//   count               pairs accepted in the current or last run
module hd_vector_gen #(
    parameter int unsigned WIDTH  = 18,
    parameter int unsigned MAX_HD = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [2:0]       weight,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [2:0]       out_hd,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned SH_W  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       hd_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [CNT_W-1:0] count_q;

    logic [WIDTH-1:0] mask_c;
    logic [WIDTH-1:0] lowbit_c;
    logic [WIDTH-1:0] ripple_c;
    logic [WIDTH-1:0] next_mask_d;
    logic [WIDTH-1:0] first_mask_c;
    logic [WIDTH-1:0] last_mask_c;
    logic [IDX_W-1:0] lsb_idx_c;
    logic             legal_c;
    logic             last_c;
    logic             fire_c;

    // The current mask is recovered from the payload registers, so it needs no storage of its own.
    assign mask_c = a_q ^ b_q;

    // Weight must be non-zero and fit both the distance limit and the word.
    assign legal_c = (weight != 3'd0) && (32'(weight) <= MAX_HD) && (32'(weight) <= WIDTH);

    // Lowest mask of a weight is its ones packed at the bottom; highest is packed at the top.
    assign first_mask_c = ~({WIDTH{1'b1}} << weight);
    assign last_mask_c  = (~({WIDTH{1'b1}} << hd_q)) << (SH_W'(WIDTH) - SH_W'(hd_q));
    assign last_c       = (mask_c == last_mask_c);

    assign fire_c = valid_q & out_ready;

    // Index of the lowest set mask bit; replaces the divide in Gosper's step with a shift.
    always_comb begin
        lsb_idx_c = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (mask_c[i]) begin
                lsb_idx_c = IDX_W'(i);
            end
        end
    end

    // Gosper successor: next larger integer with the same popcount.
    assign lowbit_c    = mask_c & (~mask_c + WIDTH'(1));
    assign ripple_c    = mask_c + lowbit_c;
    assign next_mask_d = ripple_c | (((ripple_c ^ mask_c) >> 2) >> lsb_idx_c);

    // Control FSM and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            hd_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (legal_c) begin
                            a_q     <= base;
                            b_q     <= base ^ first_mask_c;
                            hd_q    <= weight;
                            count_q <= '0;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= GEN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                GEN: begin
                    // Abort wins over a coincident handshake; that pair is not counted.
                    if (abort) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (fire_c) begin
                        count_q <= count_q + CNT_W'(1);
                        if (last_c) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            b_q <= a_q ^ next_mask_d;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_hd    = hd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule
